// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1, LSB first, mid-bit sampling. Each good byte is
// presented as a one-cycle valid_byte pulse; a low stop bit gives framing_err.
module midi_uart_rx #(
    parameter int CLKS_PER_BIT = 3200,
    parameter int CNT_W        = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       valid_byte,
    output logic [7:0] data,
    output logic       framing_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_meta;
    logic             rxs;

    // Synchroniser resets to 1 so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // NOTE: non-blocking throughout, so every branch sees the pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data        <= '0;
            valid_byte  <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid_byte  <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_CNT) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == LAST_CNT) begin
                        timer   <= '0;
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == LAST_CNT) begin
                        timer <= '0;
                        if (rxs) begin
                            data       <= shift;
                            valid_byte <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line yields one error only; wait for release.
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
